if_prefetch: RTL and testbench
==============================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter ADDR_W, default 16, PC and instruction-memory address width.
REQ-002 Parameter DATA_W, default 16, instruction width.
REQ-003 Parameter DEPTH, default 4, instruction buffer entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, fetch address loaded at reset.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 nRst  input  1  asynchronous, active-low reset.
REQ-007 hlt  input  1  stop issuing new fetch requests.
REQ-008 useAlt  input  1  redirect: flush and refetch from altAddress.
REQ-009 altAddress  input  ADDR_W  redirect target.
REQ-010 imemReq  output  1  fetch request, always accepted by memory the same cycle.
REQ-011 imemAddr  output  ADDR_W  address of current request.
REQ-012 imemValid  input  1  response valid; responses return in request order, latency >= 1 cycle.
REQ-013 imemData  input  DATA_W  response instruction.
REQ-014 instrValid  output  1  buffer head valid.
REQ-015 instr  output  DATA_W  buffer head instruction.
REQ-016 instrPc  output  ADDR_W  address of buffer head instruction.
REQ-017 instrReady  input  1  decode accepts head this cycle.
REQ-018 pc  output  ADDR_W  next fetch address (fetchPc).

Function
REQ-019 outst counts issued-but-unanswered requests; dropCnt counts outstanding responses to discard; count = buffer occupancy.
REQ-020 imemReq SHALL be 1 iff !hlt && !useAlt && (count + outst) < DEPTH; imemAddr = fetchPc.
REQ-021 Each issued request: fetchPc <= fetchPc + 1, wrapping modulo 2^ADDR_W; outst + 1.
REQ-022 Each imemValid: outst - 1; if dropCnt > 0, data discarded and dropCnt - 1; else pushed with tag respPc, respPc <= respPc + 1 (wrapping).
REQ-023 Issue and response in the same cycle: outst unchanged.
REQ-024 Credit rule guarantees no push to a full buffer; overflow is unreachable.
REQ-025 instrValid = (count != 0) && !useAlt; instr/instrPc = head entry; pop when instrValid && instrReady.
REQ-026 Push and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-027 useAlt has priority over all: buffer emptied, fetchPc <= altAddress, respPc <= altAddress, no request issued, pop ignored, any imemValid that cycle discarded, dropCnt <= outst - imemValid (as counted before the cycle).
REQ-028 Consecutive useAlt cycles: last altAddress wins; dropCnt recomputed each cycle.
REQ-029 hlt: fetchPc holds; outstanding responses still accepted/dropped per REQ-022; decode may still drain buffer.
REQ-030 imemValid while outst == 0 SHALL be ignored (protocol violation, no state change).

Reset
REQ-031 nRst low asynchronously: fetchPc = respPc = RESET_PC, count = outst = dropCnt = 0; imemReq = 0, instrValid = 0 while nRst low.
REQ-032 Reset mid-operation discards buffer and all outstanding responses; responses after reset release with outst == 0 are ignored per REQ-030.
REQ-033 First request issues in the first clk edge after nRst rises, absent hlt/useAlt.

Verification (DEPTH=4, RESET_PC=0, 1-cycle memory unless stated)
REQ-034 Reset release, instrReady=1 -> imemAddr 0,1,2,... on consecutive cycles; instr/instrPc pairs (mem[0],0),(mem[1],1) one cycle after each request.
REQ-035 instrReady=0 for 10 cycles -> exactly 4 requests (0..3), count=4, imemReq=0; instrReady=1 -> pops 0..3 in order, requests resume at 4.
REQ-036 3-cycle memory latency, useAlt with altAddress=0x0100 while 3 requests outstanding -> dropCnt=3, three stale responses discarded, first instrPc=0x0100.
REQ-037 hlt asserted with 2 outstanding -> both buffered and delivered, pc holds, imemReq=0 until hlt deasserted.
REQ-038 fetchPc=0xFFFF, ADDR_W=16 -> next request address 0x0000, instrPc wraps identically.
REQ-039 nRst pulsed low with full buffer and 2 outstanding -> instrValid=0 immediately; after release, late imemValid pulses ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_if.sv
// Fetch-side bus bundle: control, instruction-memory port and decode port.
interface if_prefetch_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              hlt;
   logic              useAlt;
   logic [ADDR_W-1:0] altAddress;
   logic              imemReq;
   logic [ADDR_W-1:0] imemAddr;
   logic              imemValid;
   logic [DATA_W-1:0] imemData;
   logic              instrValid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instrPc;
   logic              instrReady;
   logic [ADDR_W-1:0] pc;

   modport master (
      input  hlt, useAlt, altAddress, imemValid, imemData, instrReady,
      output imemReq, imemAddr, instrValid, instr, instrPc, pc
   );

   modport slave (
      output hlt, useAlt, altAddress, imemValid, imemData, instrReady,
      input  imemReq, imemAddr, instrValid, instr, instrPc, pc
   );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetcher: credit-limited in-order fetch into a small FIFO,
// with redirect flush that discards responses still in flight.
module if_prefetch #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic           clk,
   input logic           nRst,
   if_prefetch_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [ADDR_W-1:0] r_fetchPc;
   logic [ADDR_W-1:0] r_respPc;
   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_outst;
   logic [CNT_W-1:0]  r_dropCnt;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [ADDR_W-1:0] r_tag  [DEPTH];

   logic [CNT_W:0]    w_used;
   logic              w_issue;
   logic              w_rsp;
   logic              w_push;
   logic              w_valid;
   logic              w_pop;

   // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
   assign w_used  = {1'b0, r_count} + {1'b0, r_outst};
   assign w_issue = nRst && !bus.hlt && !bus.useAlt && (w_used < DEPTH_C);
   assign w_rsp   = bus.imemValid && (r_outst != '0);
   assign w_push  = w_rsp && (r_dropCnt == '0) && !bus.useAlt;
   assign w_valid = (r_count != '0) && !bus.useAlt;
   assign w_pop   = w_valid && bus.instrReady;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_fetchPc <= RESET_PC;
         r_respPc  <= RESET_PC;
         r_count   <= '0;
         r_outst   <= '0;
         r_dropCnt <= '0;
         r_head    <= '0;
         r_tail    <= '0;
      end else if (bus.useAlt) begin
         // Everything still in flight after this cycle belongs to the old stream.
         r_fetchPc <= bus.altAddress;
         r_respPc  <= bus.altAddress;
         r_count   <= '0;
         r_head    <= '0;
         r_tail    <= '0;
         r_outst   <= r_outst - CNT_W'(w_rsp);
         r_dropCnt <= r_outst - CNT_W'(w_rsp);
      end else begin
         if (w_issue) begin
            r_fetchPc <= r_fetchPc + 1'b1;
         end
         r_outst <= r_outst + CNT_W'(w_issue) - CNT_W'(w_rsp);
         if (w_rsp && (r_dropCnt != '0)) begin
            r_dropCnt <= r_dropCnt - 1'b1;
         end
         if (w_push) begin
            r_tail   <= r_tail + 1'b1;
            r_respPc <= r_respPc + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_data[r_tail] <= bus.imemData;
         r_tag[r_tail]  <= r_respPc;
      end
   end

   assign bus.imemReq    = w_issue;
   assign bus.imemAddr   = r_fetchPc;
   assign bus.pc         = r_fetchPc;
   assign bus.instrValid = w_valid;
   assign bus.instr      = r_data[r_head];
   assign bus.instrPc    = r_tag[r_head];
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-level fetch model plus an in-order memory responder.
module tb_if_prefetch;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic clk  = 1'b0;
   logic nRst = 1'b0;

   if_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   if_prefetch #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .DEPTH   (DEPTH),
      .RESET_PC(16'h0000)
   ) dut (
      .clk (clk),
      .nRst(nRst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] data;
   } ent_t;

   typedef struct {
      int            due;
      logic [AW-1:0] addr;
   } mreq_t;

   ent_t          q[$];
   mreq_t         mq[$];
   int            m_outst, m_drop;
   logic [AW-1:0] m_fpc, m_rpc;
   int            cyc, last_due, lat_min, lat_max, spur_pct, req_seen;
   int            n_vec, n_err;
   logic          s_req, s_valid;
   logic [AW-1:0] s_addr, s_pc, s_ipc;
   logic [DW-1:0] s_instr;

   function automatic logic [DW-1:0] memdata(input logic [AW-1:0] a);
      logic [31:0] p;
      p = {16'h0000, a} * 32'h0000_9E37;
      return p[15:0] ^ 16'h5A5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive memory response, compare at negedge, advance model.
   task automatic step();
      bit real_rsp, ereq, evalid, rv;
      int due;
      cyc++;
      real_rsp = (mq.size() > 0) && (mq[0].due <= cyc);
      if (real_rsp) begin
         bus.imemValid = 1'b1;
         bus.imemData  = memdata(mq[0].addr);
      end else if (mq.size() == 0 && m_outst == 0 && nRst && $urandom_range(99) < spur_pct) begin
         bus.imemValid = 1'b1;
         bus.imemData  = DW'($urandom);
      end else begin
         bus.imemValid = 1'b0;
         bus.imemData  = '0;
      end
      @(negedge clk);
      ereq   = nRst && !bus.hlt && !bus.useAlt && (q.size() + m_outst < DEPTH);
      evalid = nRst && (q.size() != 0) && !bus.useAlt;
      s_req = bus.imemReq;  s_addr = bus.imemAddr;  s_pc = bus.pc;
      s_valid = bus.instrValid;  s_instr = bus.instr;  s_ipc = bus.instrPc;
      check("imemReq", bus.imemReq, ereq);
      if (ereq) check("imemAddr", bus.imemAddr, m_fpc);
      check("pc", bus.pc, m_fpc);
      check("instrValid", bus.instrValid, evalid);
      if (evalid) begin
         check("instr", bus.instr, q[0].data);
         check("instrPc", bus.instrPc, q[0].pc);
      end
      if (real_rsp) void'(mq.pop_front());
      if (bus.imemReq) begin
         due = cyc + int'($urandom_range(lat_max, lat_min));
         if (due <= last_due) due = last_due + 1;
         mq.push_back('{due, bus.imemAddr});
         last_due = due;
         req_seen++;
      end
      if (nRst) begin
         rv = bus.imemValid && (m_outst > 0);
         if (bus.useAlt) begin
            q.delete();
            m_fpc   = bus.altAddress;
            m_rpc   = bus.altAddress;
            m_outst = m_outst - int'(rv);
            m_drop  = m_outst;
         end else begin
            if (evalid && bus.instrReady) void'(q.pop_front());
            if (ereq) begin
               m_fpc++;
               m_outst++;
            end
            if (rv) begin
               m_outst--;
               if (m_drop > 0) m_drop--;
               else begin
                  q.push_back('{pc: m_rpc, data: bus.imemData});
                  m_rpc++;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int hold);
      nRst = 1'b0;
      #1;
      check("rst_imemReq", bus.imemReq, 0);
      check("rst_instrValid", bus.instrValid, 0);
      check("rst_pc", bus.pc, 0);
      q.delete();
      m_outst = 0; m_drop = 0; m_fpc = '0; m_rpc = '0;
      repeat (hold) step();
      nRst = 1'b1;
      req_seen = 0;
   endtask

   initial begin
      int r0;
      bit found;
      bus.hlt = 1'b0; bus.useAlt = 1'b0; bus.altAddress = '0;
      bus.imemValid = 1'b0; bus.imemData = '0; bus.instrReady = 1'b0;
      n_vec = 0; n_err = 0; cyc = 0; last_due = 0; req_seen = 0;
      lat_min = 1; lat_max = 1; spur_pct = 0;
      q.delete(); m_outst = 0; m_drop = 0; m_fpc = '0; m_rpc = '0;
      @(posedge clk);
      #1;
      do_reset(2);

      // Streaming from reset with 1-cycle memory
      bus.instrReady = 1'b1;
      step(); check("p1_req0", s_req, 1); check("p1_addr0", s_addr, 16'h0000);
      step(); check("p1_addr1", s_addr, 16'h0001); check("p1_nvalid", s_valid, 0);
      step(); check("p1_valid", s_valid, 1); check("p1_ipc0", s_ipc, 16'h0000);
      check("p1_instr0", s_instr, 16'h5A5A);
      step(); check("p1_ipc1", s_ipc, 16'h0001); check("p1_instr1", s_instr, 16'hC46D);
      check("p1_addr3", s_addr, 16'h0003);
      repeat (10) step();

      // Decode stalled: credit stops fetch at DEPTH
      do_reset(2);
      bus.instrReady = 1'b0;
      repeat (10) step();
      check("p2_reqs", req_seen, 4);
      check("p2_req_off", s_req, 0);
      check("p2_pc", s_pc, 16'h0004);
      check("p2_head", s_ipc, 16'h0000);
      bus.instrReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("p2_pop_pc", s_ipc, i);
         if (i == 1) begin
            check("p2_resume_req", s_req, 1);
            check("p2_resume_addr", s_addr, 16'h0004);
         end
      end

      // Redirect with 3-cycle memory and responses in flight
      do_reset(2);
      lat_min = 3; lat_max = 3;
      repeat (3) step();
      bus.useAlt = 1'b1; bus.altAddress = 16'h0100;
      step(); check("p3_alt_req", s_req, 0); check("p3_alt_valid", s_valid, 0);
      bus.useAlt = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (s_valid) begin
            found = 1'b1;
            check("p3_first_ipc", s_ipc, 16'h0100);
            check("p3_first_instr", s_instr, 16'h6D5A);
         end
      end
      check("p3_found", found, 1);

      // Halt with responses outstanding
      lat_min = 2; lat_max = 2;
      repeat (6) step();
      bus.hlt = 1'b1;
      r0 = req_seen;
      repeat (8) step();
      check("p4_hlt_reqs", req_seen - r0, 0);
      check("p4_req_off", s_req, 0);
      check("p4_drained", s_valid, 0);
      bus.hlt = 1'b0;
      step(); check("p4_resume", s_req, 1);

      // Address wrap
      lat_min = 1; lat_max = 1;
      bus.useAlt = 1'b1; bus.altAddress = 16'hFFFF;
      step();
      bus.useAlt = 1'b0;
      step(); check("p5_addr_ffff", s_addr, 16'hFFFF); check("p5_req", s_req, 1);
      step(); check("p5_addr_wrap", s_addr, 16'h0000);
      step(); check("p5_ipc_ffff", s_ipc, 16'hFFFF); check("p5_instr_ffff", s_instr, 16'h3B93);
      step(); check("p5_ipc_wrap", s_ipc, 16'h0000);

      // Reset with responses in flight; late responses must be ignored
      bus.useAlt = 1'b1; bus.altAddress = 16'h0200;
      step();
      bus.useAlt = 1'b0; bus.instrReady = 1'b0;
      lat_min = 3; lat_max = 3;
      repeat (3) step();
      bus.hlt = 1'b1;
      do_reset(2);
      spur_pct = 30;
      for (int k = 0; k < 20 && mq.size() > 0; k++) step();
      repeat (3) step();
      bus.hlt = 1'b0;
      step(); check("p6_restart_req", s_req, 1); check("p6_restart_addr", s_addr, 16'h0000);

      // Randomized traffic
      spur_pct = 5; lat_min = 1; lat_max = 4;
      for (int n = 0; n < 3000; n++) begin
         bus.hlt        = ($urandom_range(99) < 15);
         bus.useAlt     = ($urandom_range(99) < 4);
         bus.altAddress = AW'($urandom);
         bus.instrReady = ($urandom_range(99) < 70);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
